iopmp_req_gate: RTL
===================

Name: iopmp_req_gate

Overview:
- Request-side gate placed directly upstream of the IOPMP checker, between a DMA/peripheral master port and the memory bus.
- Registers each master request and presents its address, write flag and source ID to the checker's port-0 lookup.
- Samples the deny result, then either forwards the request downstream or returns an error response to the master.
- Captures the first violation in sticky syndrome registers, counts later violations, and raises a level interrupt to the TEE CPU.

Parameters:
ADDR_W, 32, request/check address width
SRC_W, 3, source ID width
CNT_W, 8, violation counter width (saturating)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_req_valid  in  1  master request valid
m_req_ready  out  1  gate accepts request
m_req_addr  in  ADDR_W  master request address
m_req_write  in  1  1=write, 0=read
m_req_src  in  SRC_W  master source ID
chk_valid  out  1  to checker input_addr_0_valid
chk_addr  out  ADDR_W  to checker input_addr_0
chk_write  out  1  to checker input_addr_0_write
chk_src  out  SRC_W  to checker source_ID
chk_deny  in  1  from checker input_addr_0_deny (combinational)
s_req_valid  out  1  downstream request valid
s_req_ready  in  1  downstream accepts
s_req_addr  out  ADDR_W  forwarded address
s_req_write  out  1  forwarded write flag
s_req_src  out  SRC_W  forwarded source ID
m_err_valid  out  1  error response to master
m_err_ready  in  1  master accepts error response
viol_valid  out  1  syndrome registers hold a captured violation
viol_addr  out  ADDR_W  captured violating address
viol_src  out  SRC_W  captured source ID
viol_write  out  1  captured write flag
viol_cnt  out  CNT_W  violations since last clear, saturating
irq  out  1  violation interrupt (level)
irq_clr  in  1  one-cycle pulse from CPU: clear syndrome, count and irq

Behaviour:
- Clock and reset: single clock domain, clk; asynchronous active-low reset rst_n.
- Reset values: FSM=IDLE; all outputs 0 except m_req_ready=1; holding registers cleared.
- FSM states:
  - IDLE: m_req_ready=1. On m_req_valid, latch addr/write/src into the holding register and go to CHECK.
  - CHECK: exactly one cycle. chk_valid=1; chk_addr/write/src come from the holding register. Sample chk_deny at the clock edge: deny=0 goes to FWD, deny=1 goes to ERR.
  - FWD: s_req_valid=1 with the held fields. On s_req_ready, return to IDLE.
  - ERR: m_err_valid=1. On m_err_ready, return to IDLE.
- Outside CHECK, chk_valid=0. chk_addr/write/src still drive the held values.
- Latency: request accepted at edge N; s_req_valid or m_err_valid asserts in cycle N+2; minimum 3 cycles per transaction.
- m_req_ready=0 in CHECK, FWD and ERR. Only one request is outstanding.
- Held fields and s_req_valid/m_err_valid stay stable until the handshake completes, whatever the state of ready.
- The gate never forwards a denied request and never error-responds to an allowed one. Source-0 bypass is decided by the checker; the gate obeys chk_deny only.
- Violation capture happens at the CHECK edge when chk_deny=1:
  - If viol_valid=0: load viol_addr/src/write, set viol_valid=1 and irq=1.
  - If viol_valid=1: syndrome registers are unchanged (first-violation sticky).
  - In both cases viol_cnt increments, saturating at 2^CNT_W-1.
- irq_clr clears viol_valid, irq, viol_cnt and the syndrome fields.
- irq_clr in the same cycle as a violation capture: the new violation wins. Syndrome loads the new fields, viol_cnt=1, irq stays 1.
- irq_clr has no effect on the request FSM.
- Reset mid-transaction: FSM returns to IDLE immediately. Pending s_req_valid/m_err_valid drop with no completion, and syndrome registers are lost.

Test Plan:
- Allowed path: src=1, addr=0x8000_0100, read, chk_deny=0 → s_req_valid in cycle N+2 with addr 0x8000_0100, write=0, src=1; m_err_valid never asserts; viol_cnt=0.
- Denied write: src=2, addr=0x2000_0000, write, chk_deny=1 → m_err_valid=1 in cycle N+2, s_req_valid stays 0; viol_valid=1, viol_addr=0x2000_0000, viol_src=2, viol_write=1, irq=1, viol_cnt=1.
- Backpressure: hold s_req_ready=0 for 5 cycles → s_req_valid and s_req fields stable, m_req_ready=0 throughout; completion occurs on the first cycle with ready=1.
- Sticky capture and saturation (CNT_W=2): 5 denied requests at addresses A0..A4 → viol_addr=A0, viol_cnt=3; irq_clr pulse → viol_valid=0, irq=0, viol_cnt=0.
- Simultaneous clear and violation: irq_clr asserted on the CHECK edge of a denied addr=0x3000_0000 → viol_addr=0x3000_0000, viol_cnt=1, irq=1.
- Reset mid-ERR: assert rst_n=0 while m_err_valid=1 → outputs return to reset values asynchronously (m_req_ready=1, irq=0); the next request completes normally.

Source files
------------

// File: rtl/iopmp_req_gate.sv
// Request-side gate in front of the IOPMP checker.
// Holds one master request, presents it to the checker for a single cycle,
// then forwards it downstream or returns an error response. The first denied
// request is kept in sticky syndrome registers and raises a level interrupt.
// Later denials only advance a saturating counter.
module iopmp_req_gate #(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req_valid,
    output logic              m_req_ready,
    input  logic [ADDR_W-1:0] m_req_addr,
    input  logic              m_req_write,
    input  logic [SRC_W-1:0]  m_req_src,
    output logic              chk_valid,
    output logic [ADDR_W-1:0] chk_addr,
    output logic              chk_write,
    output logic [SRC_W-1:0]  chk_src,
    input  logic              chk_deny,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_req_addr,
    output logic              s_req_write,
    output logic [SRC_W-1:0]  s_req_src,
    output logic              m_err_valid,
    input  logic              m_err_ready,
    output logic              viol_valid,
    output logic [ADDR_W-1:0] viol_addr,
    output logic [SRC_W-1:0]  viol_src,
    output logic              viol_write,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic              irq,
    input  logic              irq_clr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_FWD   = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [ADDR_W-1:0] hold_addr_r;
    logic              hold_write_r;
    logic [SRC_W-1:0]  hold_src_r;
    logic              m_req_ready_r;
    logic              chk_valid_r;
    logic              s_req_valid_r;
    logic              m_err_valid_r;
    logic              viol_valid_r;
    logic [ADDR_W-1:0] viol_addr_r;
    logic [SRC_W-1:0]  viol_src_r;
    logic              viol_write_r;
    logic [CNT_W-1:0]  viol_cnt_r;
    logic              irq_r;
    logic              viol_hit_s;

    // A violation is only ever taken from the single CHECK cycle.
    assign viol_hit_s = (state_r == ST_CHECK) && chk_deny;

    // Next-state decode of the one-outstanding-request FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (m_req_valid) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (chk_deny) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_FWD;
                end
            end
            ST_FWD: begin
                if (s_req_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FWD;
                end
            end
            ST_ERR: begin
                if (m_err_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ERR;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            m_req_ready_r <= 1'b1;
            chk_valid_r   <= 1'b0;
            s_req_valid_r <= 1'b0;
            m_err_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            m_req_ready_r <= (state_s == ST_IDLE);
            chk_valid_r   <= (state_s == ST_CHECK);
            s_req_valid_r <= (state_s == ST_FWD);
            m_err_valid_r <= (state_s == ST_ERR);
        end
    end

    // Holding register: loaded only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_write_r <= 1'b0;
            hold_src_r   <= {SRC_W{1'b0}};
        end else if ((state_r == ST_IDLE) && m_req_valid) begin
            hold_addr_r  <= m_req_addr;
            hold_write_r <= m_req_write;
            hold_src_r   <= m_req_src;
        end
    end

    // Syndrome capture: first violation sticks, a coincident clear loses to a new violation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_valid_r <= 1'b0;
            viol_addr_r  <= {ADDR_W{1'b0}};
            viol_src_r   <= {SRC_W{1'b0}};
            viol_write_r <= 1'b0;
            viol_cnt_r   <= CNT_ZERO;
            irq_r        <= 1'b0;
        end else if (viol_hit_s) begin
            if (!viol_valid_r || irq_clr) begin
                viol_addr_r  <= hold_addr_r;
                viol_src_r   <= hold_src_r;
                viol_write_r <= hold_write_r;
            end
            viol_valid_r <= 1'b1;
            irq_r        <= 1'b1;
            viol_cnt_r   <= irq_clr ? CNT_ONE : sat_inc(viol_cnt_r);
        end else if (irq_clr) begin
            viol_valid_r <= 1'b0;
            viol_addr_r  <= {ADDR_W{1'b0}};
            viol_src_r   <= {SRC_W{1'b0}};
            viol_write_r <= 1'b0;
            viol_cnt_r   <= CNT_ZERO;
            irq_r        <= 1'b0;
        end
    end

    assign m_req_ready = m_req_ready_r;
    assign chk_valid   = chk_valid_r;
    assign chk_addr    = hold_addr_r;
    assign chk_write   = hold_write_r;
    assign chk_src     = hold_src_r;
    assign s_req_valid = s_req_valid_r;
    assign s_req_addr  = hold_addr_r;
    assign s_req_write = hold_write_r;
    assign s_req_src   = hold_src_r;
    assign m_err_valid = m_err_valid_r;
    assign viol_valid  = viol_valid_r;
    assign viol_addr   = viol_addr_r;
    assign viol_src    = viol_src_r;
    assign viol_write  = viol_write_r;
    assign viol_cnt    = viol_cnt_r;
    assign irq         = irq_r;

endmodule
